// File: rtl/dcdl_code_applier_pkg.sv
// Delay-line constants, FSM state type and the coarse stepping helper shared by
// the DCDL code applier and its decoder.
package dcdl_code_applier_pkg;

  localparam int COARSE_W = 4;
  localparam int FINE_W   = 6;
  localparam int NTAP     = 16;
  localparam int DCODE_W  = COARSE_W + FINE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    FINE = 2'd2
  } state_e;

  // One tap toward the target; the target is always a legal tap, so no wrap.
  function automatic logic [COARSE_W-1:0] step_toward(
    input logic [COARSE_W-1:0] cur,
    input logic [COARSE_W-1:0] tgt
  );
    logic [COARSE_W-1:0] nxt;
    if (tgt > cur) begin
      nxt = cur + 4'd1;
    end else if (tgt < cur) begin
      nxt = cur - 4'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dcdl_code_applier_if.sv
// Code request handshake from the SAR loop plus the delay-line drive outputs.
interface dcdl_code_applier_if;
  import dcdl_code_applier_pkg::*;

  logic [DCODE_W-1:0] Q;
  logic               Q_valid;
  logic               Q_ready;
  logic [NTAP-1:0]    T;
  logic [NTAP-1:0]    Tb;
  logic [FINE_W-1:0]  fine;
  logic [DCODE_W-1:0] code_cur;
  logic               busy;
  logic               done;

  modport master (
    output Q, Q_valid,
    input  Q_ready, T, Tb, fine, code_cur, busy, done
  );

  modport slave (
    input  Q, Q_valid,
    output Q_ready, T, Tb, fine, code_cur, busy, done
  );

endinterface

// File: rtl/dcdl_code_applier_coarse_therm_dec.sv
// Coarse value to complementary thermometer pair: T[i]=1 iff i <= coarse.
module coarse_therm_dec
  import dcdl_code_applier_pkg::*;
(
  input  logic [COARSE_W-1:0] coarse_i,
  output logic [NTAP-1:0]     t_o,
  output logic [NTAP-1:0]     tb_o
);

  logic [NTAP-1:0] t_s;

  // Compare every tap index against the coarse value.
  always_comb begin
    t_s = {NTAP{1'b0}};
    for (int i = 0; i < NTAP; i++) begin
      if (COARSE_W'(i) <= coarse_i) begin
        t_s[i] = 1'b1;
      end else begin
        t_s[i] = 1'b0;
      end
    end
  end

  assign t_o  = t_s;
  assign tb_o = ~t_s;

endmodule

// File: rtl/dcdl_code_applier.sv
// Applies a SAR delay code to the DCDL: coarse taps walk one at a time with
// STEP_CYC-cycle gaps, then fine is loaded and done pulses.
module dcdl_code_applier
  import dcdl_code_applier_pkg::*;
#(
  parameter int CODE_W   = 10,
  parameter int STEP_CYC = 4
) (
  input logic                CLK_exit,
  input logic                Reset,
  dcdl_code_applier_if.slave bus
);

  localparam logic [3:0] STEP_LAST = 4'(STEP_CYC - 1);

  state_e              state_q, state_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [COARSE_W-1:0] tgt_c_q, tgt_c_d;
  logic [FINE_W-1:0]   fine_q, fine_d;
  logic [FINE_W-1:0]   tgt_f_q, tgt_f_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept_s;
  logic [NTAP-1:0]     t_s, tb_s;

  assign accept_s = bus.Q_valid && ready_q && (state_q == IDLE);

  // Next-state and datapath updates for the IDLE/STEP/FINE sequence.
  always_comb begin
    state_d  = state_q;
    coarse_d = coarse_q;
    tgt_c_d  = tgt_c_q;
    fine_d   = fine_q;
    tgt_f_d  = tgt_f_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    busy_d   = (state_q != IDLE);
    ready_d  = (state_q == IDLE) && !accept_s;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          tgt_c_d = bus.Q[CODE_W-1 -: COARSE_W];
          tgt_f_d = bus.Q[FINE_W-1:0];
          cnt_d   = 4'd0;
          state_d = STEP;
        end else begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (coarse_q == tgt_c_q) begin
          cnt_d   = 4'd0;
          state_d = FINE;
        end else if (cnt_q == STEP_LAST) begin
          coarse_d = step_toward(coarse_q, tgt_c_q);
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FINE: begin
        fine_d  = tgt_f_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending target.
  always_ff @(posedge CLK_exit or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      coarse_q <= 4'd0;
      tgt_c_q  <= 4'd0;
      fine_q   <= 6'd0;
      tgt_f_q  <= 6'd0;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      coarse_q <= coarse_d;
      tgt_c_q  <= tgt_c_d;
      fine_q   <= fine_d;
      tgt_f_q  <= tgt_f_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  coarse_therm_dec u_therm (
    .coarse_i (coarse_q),
    .t_o      (t_s),
    .tb_o     (tb_s)
  );

  assign bus.T        = t_s;
  assign bus.Tb       = tb_s;
  assign bus.fine     = fine_q;
  assign bus.code_cur = {coarse_q, fine_q};
  assign bus.Q_ready  = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_dcdl_code_applier.sv
// Directed bench for dcdl_code_applier: one instance with STEP_CYC=4, one with STEP_CYC=1.
module tb_dcdl_code_applier;

  logic CLK_exit;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  dcdl_code_applier_if bus4 ();
  dcdl_code_applier_if bus1 ();

  dcdl_code_applier #(.CODE_W(10), .STEP_CYC(4)) dut4 (
    .CLK_exit (CLK_exit),
    .Reset    (Reset),
    .bus      (bus4)
  );

  dcdl_code_applier #(.CODE_W(10), .STEP_CYC(1)) dut1 (
    .CLK_exit (CLK_exit),
    .Reset    (Reset),
    .bus      (bus1)
  );

  initial CLK_exit = 1'b0;
  always #5 CLK_exit = ~CLK_exit;

  function automatic logic [15:0] therm(input int c);
    logic [16:0] v;
    v = (17'd1 << (c + 1)) - 17'd1;
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge CLK_exit);
    #1;
  endtask

  task automatic send4(input logic [9:0] q);
    bus4.Q       = q;
    bus4.Q_valid = 1'b1;
    tick();
    bus4.Q_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus4.Q = 10'd0; bus4.Q_valid = 1'b0;
    bus1.Q = 10'd0; bus1.Q_valid = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (bus4.T !== 16'h0001 || bus4.Tb !== 16'hFFFE || bus4.fine !== 6'd0 ||
        bus4.Q_ready !== 1'b1 || bus4.done !== 1'b0 || bus4.busy !== 1'b0 ||
        bus4.code_cur !== 10'd0) begin
      errors++;
      $display("FAIL reset_vals got T=%h Tb=%h fine=%0d rdy=%b done=%b busy=%b cur=%h want 0001 fffe 0 1 0 0 000",
               bus4.T, bus4.Tb, bus4.fine, bus4.Q_ready, bus4.done, bus4.busy, bus4.code_cur);
    end
    send4(10'h0C5);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (bus4.T !== ((e < 4) ? 16'h0001 : 16'h0003)) begin
        errors++;
        $display("FAIL reset_pre_T e=%0d got %h want %h", e, bus4.T, (e < 4) ? 16'h0001 : 16'h0003);
      end
    end
    @(negedge CLK_exit);
    Reset = 1'b1;
    #1;
    checks++;
    if (bus4.T !== 16'h0001 || bus4.Tb !== 16'hFFFE || bus4.fine !== 6'd0 ||
        bus4.Q_ready !== 1'b1 || bus4.done !== 1'b0 || bus4.busy !== 1'b0 ||
        bus4.code_cur !== 10'd0) begin
      errors++;
      $display("FAIL reset_async got T=%h Tb=%h fine=%0d rdy=%b done=%b busy=%b cur=%h want 0001 fffe 0 1 0 0 000",
               bus4.T, bus4.Tb, bus4.fine, bus4.Q_ready, bus4.done, bus4.busy, bus4.code_cur);
    end
    repeat (2) tick();
    Reset = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (bus4.done !== 1'b0 || bus4.T !== 16'h0001 || bus4.Q_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_discard c=%0d got done=%b T=%h rdy=%b want 0 0001 1", e, bus4.done, bus4.T, bus4.Q_ready);
      end
    end
  endtask

  task automatic test_up();
    int c;
    logic [5:0] f;
    send4(10'h0C5);
    for (int e = 1; e <= 16; e++) begin
      tick();
      c = (e < 4) ? 0 : (e < 8) ? 1 : (e < 12) ? 2 : 3;
      f = (e >= 14) ? 6'd5 : 6'd0;
      checks++;
      if (bus4.T !== therm(c) || bus4.Tb !== ~therm(c) || bus4.fine !== f ||
          bus4.done !== (e == 14) || bus4.Q_ready !== (e >= 15) ||
          bus4.busy !== (e <= 14) || bus4.code_cur !== {4'(c), f}) begin
        errors++;
        $display("FAIL up e=%0d got T=%h Tb=%h fine=%0d done=%b rdy=%b busy=%b want T=%h fine=%0d done=%b rdy=%b busy=%b",
                 e, bus4.T, bus4.Tb, bus4.fine, bus4.done, bus4.Q_ready, bus4.busy,
                 therm(c), f, (e == 14), (e >= 15), (e <= 14));
      end
    end
  endtask

  task automatic test_down();
    int c;
    logic [5:0] f;
    send4(10'h07F);
    for (int e = 1; e <= 12; e++) begin
      tick();
      c = (e < 4) ? 3 : (e < 8) ? 2 : 1;
      f = (e >= 10) ? 6'd63 : 6'd5;
      checks++;
      if (bus4.T !== therm(c) || bus4.Tb !== ~therm(c) || bus4.fine !== f ||
          bus4.done !== (e == 10) || bus4.Q_ready !== (e >= 11) ||
          bus4.busy !== (e <= 10) || bus4.code_cur !== {4'(c), f}) begin
        errors++;
        $display("FAIL down e=%0d got T=%h fine=%0d done=%b rdy=%b busy=%b want T=%h fine=%0d done=%b rdy=%b busy=%b",
                 e, bus4.T, bus4.fine, bus4.done, bus4.Q_ready, bus4.busy,
                 therm(c), f, (e == 10), (e >= 11), (e <= 10));
      end
    end
  endtask

  task automatic test_same();
    send4(10'h07F);
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (bus4.T !== 16'h0003 || bus4.fine !== 6'd63 || bus4.done !== (e == 2) ||
          bus4.busy !== (e <= 2) || bus4.Q_ready !== (e >= 3)) begin
        errors++;
        $display("FAIL same e=%0d got T=%h fine=%0d done=%b busy=%b rdy=%b want 0003 63 %b %b %b",
                 e, bus4.T, bus4.fine, bus4.done, bus4.busy, bus4.Q_ready, (e == 2), (e <= 2), (e >= 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    logic [5:0] f;
    logic rdy, bsy;
    bus4.Q       = 10'h0C5;
    bus4.Q_valid = 1'b1;
    tick();
    bus4.Q = 10'h3C0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e <= 11) begin
        c = (e < 4) ? 1 : (e < 8) ? 2 : 3;
      end else begin
        c = 3 + (((e - 12) / 4 > 12) ? 12 : (e - 12) / 4);
      end
      f   = (e < 10) ? 6'd63 : (e < 62) ? 6'd5 : 6'd0;
      rdy = (e == 11) || (e >= 63);
      bsy = (e >= 1 && e <= 10) || (e >= 13 && e <= 62);
      checks++;
      if (bus4.T !== therm(c) || bus4.fine !== f || bus4.Q_ready !== rdy ||
          bus4.busy !== bsy || bus4.done !== (e == 10 || e == 62) ||
          bus4.code_cur !== {4'(c), f}) begin
        errors++;
        $display("FAIL busy_hs e=%0d got T=%h fine=%0d rdy=%b busy=%b done=%b want T=%h fine=%0d rdy=%b busy=%b done=%b",
                 e, bus4.T, bus4.fine, bus4.Q_ready, bus4.busy, bus4.done,
                 therm(c), f, rdy, bsy, (e == 10 || e == 62));
      end
      if (e == 12) begin
        bus4.Q_valid = 1'b0;
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] prev_t;
    int c;
    prev_t       = bus1.T;
    bus1.Q       = 10'h3EA;
    bus1.Q_valid = 1'b1;
    tick();
    bus1.Q_valid = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      c = (e > 15) ? 15 : e;
      checks++;
      if ($countones(bus1.T ^ prev_t) > 1 || bus1.Tb !== ~bus1.T) begin
        errors++;
        $display("FAIL sweep_glitch e=%0d got T=%h prevT=%h Tb=%h want <=1 bit change, Tb=~T",
                 e, bus1.T, prev_t, bus1.Tb);
      end
      checks++;
      if (bus1.T !== therm(c) || bus1.done !== (e == 17) || bus1.Q_ready !== (e >= 18)) begin
        errors++;
        $display("FAIL sweep e=%0d got T=%h done=%b rdy=%b want T=%h done=%b rdy=%b",
                 e, bus1.T, bus1.done, bus1.Q_ready, therm(c), (e == 17), (e >= 18));
      end
      prev_t = bus1.T;
    end
    checks++;
    if (bus1.T !== 16'hFFFF || bus1.Tb !== 16'h0000 || bus1.code_cur !== 10'h3EA) begin
      errors++;
      $display("FAIL sweep_end got T=%h Tb=%h cur=%h want ffff 0000 3ea", bus1.T, bus1.Tb, bus1.code_cur);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_same();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
